// File: rtl/nlfsr_128_pkg.sv
// Shared definitions for the 128-bit NLFSR generator and its stream checker:
// tap positions, the state-advance function and the checker FSM states.
package nlfsr_128_pkg;

    localparam int WIDTH = 128;

    localparam int TAP_A = 127;
    localparam int TAP_B = 125;
    localparam int TAP_C = 101;
    localparam int TAP_D = 99;
    localparam int TAP_E = 90;
    localparam int TAP_F = 61;

    localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Linear taps XORed with one AND term; an all-zero state maps to itself.
    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] s);
        logic fb;
        fb = s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D] ^ (s[TAP_E] & s[TAP_F]);
        return {s[WIDTH-2:0], fb};
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == COUNT_MAX) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/nlfsr_128_step.sv
// Combinational single-step advance of the 128-bit NLFSR state.
module nlfsr_128_step
    import nlfsr_128_pkg::*;
(
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] stepped
);

    assign stepped = step(value);

endmodule

// File: rtl/nlfsr_128_checker.sv
// Synchronises to a received NLFSR word stream, then counts words and
// mismatches while locked, dropping lock after a run of bad words.
module nlfsr_128_checker
    import nlfsr_128_pkg::*;
#(
    parameter int LOCK_THRESH   = 4,
    parameter int UNLOCK_THRESH = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              data_valid,
    input  logic              clear_counts,
    output logic              locked,
    output logic              error_pulse,
    output logic [31:0]       error_count,
    output logic [31:0]       word_count
);

    localparam logic [3:0] LOCK_CNT   = 4'(LOCK_THRESH);
    localparam logic [3:0] UNLOCK_CNT = 4'(UNLOCK_THRESH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] pred;
    logic [WIDTH-1:0] pred_nxt;
    logic [WIDTH-1:0] step_data;
    logic [WIDTH-1:0] step_pred;
    logic [3:0]       good_cnt;
    logic [3:0]       good_nxt;
    logic [3:0]       bad_cnt;
    logic [3:0]       bad_nxt;
    logic             match;
    logic             is_zero;
    logic             err_hit;
    logic             word_hit;

    nlfsr_128_step u_step_data (
        .value   (data_in),
        .stepped (step_data)
    );

    nlfsr_128_step u_step_pred (
        .value   (pred),
        .stepped (step_pred)
    );

    assign match   = (data_in == pred);
    assign is_zero = (data_in == '0);

    always_comb begin
        state_nxt = state;
        pred_nxt  = pred;
        good_nxt  = good_cnt;
        bad_nxt   = bad_cnt;
        err_hit   = 1'b0;
        word_hit  = 1'b0;
        if (data_valid) begin
            unique case (state)
                HUNT: begin
                    if (!is_zero) begin
                        pred_nxt  = step_data;
                        good_nxt  = '0;
                        state_nxt = VERIFY;
                    end
                end
                VERIFY: begin
                    if (match) begin
                        pred_nxt = step_data;
                        good_nxt = good_cnt + 4'd1;
                        if (good_cnt + 4'd1 == LOCK_CNT) begin
                            state_nxt = LOCKED;
                        end
                    end else if (is_zero) begin
                        good_nxt  = '0;
                        state_nxt = HUNT;
                    end else begin
                        pred_nxt = step_data;
                        good_nxt = '0;
                    end
                end
                LOCKED: begin
                    // Once locked the prediction free-runs so one bad word costs one error.
                    pred_nxt = step_pred;
                    word_hit = 1'b1;
                    if (match) begin
                        bad_nxt = '0;
                    end else begin
                        err_hit = 1'b1;
                        if (bad_cnt + 4'd1 == UNLOCK_CNT) begin
                            bad_nxt   = '0;
                            state_nxt = HUNT;
                        end else begin
                            bad_nxt = bad_cnt + 4'd1;
                        end
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= HUNT;
            pred        <= '0;
            good_cnt    <= '0;
            bad_cnt     <= '0;
            locked      <= 1'b0;
            error_pulse <= 1'b0;
            error_count <= '0;
            word_count  <= '0;
        end else begin
            state       <= state_nxt;
            pred        <= pred_nxt;
            good_cnt    <= good_nxt;
            bad_cnt     <= bad_nxt;
            locked      <= (state_nxt == LOCKED);
            error_pulse <= err_hit;
            if (clear_counts) begin
                error_count <= '0;
                word_count  <= '0;
            end else begin
                if (err_hit) begin
                    error_count <= sat_inc(error_count);
                end
                if (word_hit) begin
                    word_count <= sat_inc(word_count);
                end
            end
        end
    end

endmodule

// File: tb/tb_nlfsr_128_checker.sv
// Table-driven scoreboard bench for nlfsr_128_checker plus hand sequences
// for counter saturation and asynchronous reset while locked.
module tb_nlfsr_128_checker;

    typedef enum int {K_GOOD, K_FLIP, K_RAND, K_ZERO, K_IDLE} kind_t;

    typedef struct {
        kind_t       kind;
        logic        clr;
        logic        exp_locked;
        logic        exp_pulse;
        logic [31:0] exp_err;
        logic [31:0] exp_words;
        int          tag;
    } vec_t;

    logic         clk          = 1'b0;
    logic         reset        = 1'b1;
    logic [127:0] data_in      = '0;
    logic         data_valid   = 1'b0;
    logic         clear_counts = 1'b0;
    logic         locked;
    logic         error_pulse;
    logic [31:0]  error_count;
    logic [31:0]  word_count;

    logic [127:0] gen;
    int           total  = 0;
    int           passed = 0;
    vec_t         vecs[$];
    vec_t         sb[$];

    nlfsr_128_checker #(
        .LOCK_THRESH   (4),
        .UNLOCK_THRESH (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .clear_counts (clear_counts),
        .locked       (locked),
        .error_pulse  (error_pulse),
        .error_count  (error_count),
        .word_count   (word_count)
    );

    always #5 clk = ~clk;

    // Independent generator model used to produce the transmitted stream.
    function automatic logic [127:0] ref_step(input logic [127:0] s);
        return {s[126:0], s[127] ^ s[125] ^ s[101] ^ s[99] ^ (s[90] & s[61])};
    endfunction

    function automatic void add(input kind_t k, input logic c, input logic l,
                                input logic p, input logic [31:0] e, input logic [31:0] w);
        vec_t v;
        v.kind       = k;
        v.clr        = c;
        v.exp_locked = l;
        v.exp_pulse  = p;
        v.exp_err    = e;
        v.exp_words  = w;
        v.tag        = vecs.size();
        vecs.push_back(v);
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input kind_t kind, input logic clr);
        clear_counts = clr;
        case (kind)
            K_GOOD: begin
                data_in    = gen;
                data_valid = 1'b1;
                gen        = ref_step(gen);
            end
            K_FLIP: begin
                data_in    = gen ^ 128'd1;
                data_valid = 1'b1;
                gen        = ref_step(gen);
            end
            K_RAND: begin
                data_in    = {$urandom(), $urandom(), $urandom(), $urandom()};
                data_valid = 1'b1;
                gen        = ref_step(gen);
            end
            K_ZERO: begin
                data_in    = '0;
                data_valid = 1'b1;
            end
            default: begin
                data_in    = {$urandom(), $urandom(), $urandom(), $urandom()};
                data_valid = 1'b0;
            end
        endcase
    endtask

    task automatic drain_one();
        vec_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check_output($sformatf("v%0d locked", e.tag), {31'd0, locked}, {31'd0, e.exp_locked});
            check_output($sformatf("v%0d error_pulse", e.tag), {31'd0, error_pulse}, {31'd0, e.exp_pulse});
            check_output($sformatf("v%0d error_count", e.tag), error_count, e.exp_err);
            check_output($sformatf("v%0d word_count", e.tag), word_count, e.exp_words);
        end
    endtask

    task automatic run_vec(input vec_t v);
        @(posedge clk);
        #1;
        drain_one();
        apply_stimulus(v.kind, v.clr);
        sb.push_back(v);
    endtask

    task automatic flush();
        @(posedge clk);
        #1;
        drain_one();
        data_valid   = 1'b0;
        clear_counts = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        gen = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

        // Lock on a clean stream: seed plus four matches, then five counted words.
        for (int i = 0; i < 4; i++) add(K_GOOD, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        add(K_GOOD, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        for (int i = 1; i <= 5; i++) add(K_GOOD, 1'b0, 1'b1, 1'b0, 32'd0, 32'(i));
        add(K_IDLE, 1'b0, 1'b1, 1'b0, 32'd0, 32'd5);
        // Single corrupted word.
        add(K_FLIP, 1'b0, 1'b1, 1'b1, 32'd1, 32'd6);
        add(K_GOOD, 1'b0, 1'b1, 1'b0, 32'd1, 32'd7);
        add(K_GOOD, 1'b0, 1'b1, 1'b0, 32'd1, 32'd8);
        // Three bad words drop lock, then relock on five good words.
        add(K_RAND, 1'b0, 1'b1, 1'b1, 32'd2, 32'd9);
        add(K_RAND, 1'b0, 1'b1, 1'b1, 32'd3, 32'd10);
        add(K_RAND, 1'b0, 1'b0, 1'b1, 32'd4, 32'd11);
        for (int i = 0; i < 4; i++) add(K_GOOD, 1'b0, 1'b0, 1'b0, 32'd4, 32'd11);
        add(K_GOOD, 1'b0, 1'b1, 1'b0, 32'd4, 32'd11);
        add(K_GOOD, 1'b0, 1'b1, 1'b0, 32'd4, 32'd12);
        // clear_counts wins over a coincident increment.
        add(K_FLIP, 1'b1, 1'b1, 1'b1, 32'd0, 32'd0);
        add(K_GOOD, 1'b0, 1'b1, 1'b0, 32'd0, 32'd1);
        add(K_GOOD, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0);
        add(K_GOOD, 1'b0, 1'b1, 1'b0, 32'd0, 32'd1);
        // Unlock, zeros ignored in HUNT, zero in VERIFY restarts the hunt.
        add(K_RAND, 1'b0, 1'b1, 1'b1, 32'd1, 32'd2);
        add(K_RAND, 1'b0, 1'b1, 1'b1, 32'd2, 32'd3);
        add(K_RAND, 1'b0, 1'b0, 1'b1, 32'd3, 32'd4);
        add(K_ZERO, 1'b0, 1'b0, 1'b0, 32'd3, 32'd4);
        add(K_ZERO, 1'b0, 1'b0, 1'b0, 32'd3, 32'd4);
        add(K_GOOD, 1'b0, 1'b0, 1'b0, 32'd3, 32'd4);
        add(K_ZERO, 1'b0, 1'b0, 1'b0, 32'd3, 32'd4);
        for (int i = 0; i < 4; i++) add(K_GOOD, 1'b0, 1'b0, 1'b0, 32'd3, 32'd4);
        add(K_GOOD, 1'b0, 1'b1, 1'b0, 32'd3, 32'd4);
        add(K_GOOD, 1'b0, 1'b1, 1'b0, 32'd3, 32'd5);

        repeat (2) @(posedge clk);
        #1;
        check_output("reset locked", {31'd0, locked}, 32'd0);
        check_output("reset error_pulse", {31'd0, error_pulse}, 32'd0);
        check_output("reset error_count", error_count, 32'd0);
        check_output("reset word_count", word_count, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);
        flush();

        // Counter saturation from a preloaded value.
        vecs.delete();
        force dut.error_count = 32'hFFFF_FFFE;
        force dut.word_count  = 32'hFFFF_FFFD;
        #1;
        release dut.error_count;
        release dut.word_count;
        check_output("force preload", error_count, 32'hFFFF_FFFE);
        add(K_FLIP, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        add(K_GOOD, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        add(K_FLIP, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        add(K_GOOD, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        add(K_FLIP, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);
        flush();

        // Asynchronous reset mid-lock with nonzero counts and a live pulse.
        #1;
        reset = 1'b1;
        #1;
        check_output("async reset locked", {31'd0, locked}, 32'd0);
        check_output("async reset error_pulse", {31'd0, error_pulse}, 32'd0);
        check_output("async reset error_count", error_count, 32'd0);
        check_output("async reset word_count", word_count, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        vecs.delete();
        for (int i = 0; i < 4; i++) add(K_GOOD, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        add(K_GOOD, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        add(K_GOOD, 1'b0, 1'b1, 1'b0, 32'd0, 32'd1);
        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);
        flush();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
